// File: rtl/ch_avg_if.sv
// Bus between the post-FFT controller, the per-symbol estimate buffer,
// the equalizer buffer and the channel-estimate averaging engine.
interface ch_avg_if #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 6
);
  logic                     ch_avg_start;
  logic                     avg_done;
  logic                     busy;
  logic                     est_rd_en;
  logic [1:0]               est_rd_sym;
  logic [IDX_W-1:0]         est_rd_idx;
  logic signed [DATA_W-1:0] est_re;
  logic signed [DATA_W-1:0] est_im;
  logic                     avg_wr_en;
  logic [IDX_W-1:0]         avg_wr_idx;
  logic signed [DATA_W-1:0] avg_re;
  logic signed [DATA_W-1:0] avg_im;

  modport master (
    output ch_avg_start, est_re, est_im,
    input  avg_done, busy, est_rd_en, est_rd_sym, est_rd_idx,
           avg_wr_en, avg_wr_idx, avg_re, avg_im
  );

  modport slave (
    input  ch_avg_start, est_re, est_im,
    output avg_done, busy, est_rd_en, est_rd_sym, est_rd_idx,
           avg_wr_en, avg_wr_idx, avg_re, avg_im
  );
endinterface

// File: rtl/ch_avg.sv
// Averages the four per-symbol DMRS channel estimates of every RE with
// half-up rounding and writes one averaged estimate per RE.
module ch_avg #(
  parameter int DATA_W = 16,
  parameter int NUM_RE = 60,
  parameter int IDX_W  = 6
) (
  input logic    clk,
  input logic    rst,
  ch_avg_if.slave bus
);
  localparam int ACC_W = DATA_W + 2;
  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_RE - 1);
  localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(2);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2} state_t;

  state_t                   state_r, state_s;
  logic                     start_prev_r, start_arm_r, start_edge_s;
  logic                     rd_en_r, rd_en_s;
  logic [1:0]               rd_sym_r, rd_sym_s;
  logic [IDX_W-1:0]         rd_idx_r, rd_idx_s;
  logic                     busy_r, busy_s;
  logic                     done_r, done_s;
  logic                     d_en_r;
  logic [1:0]               d_sym_r;
  logic [IDX_W-1:0]         d_idx_r;
  logic signed [ACC_W-1:0]  acc_re_r, acc_im_r;
  logic                     wr_en_r;
  logic [IDX_W-1:0]         wr_idx_r;
  logic signed [DATA_W-1:0] avg_re_r, avg_im_r;

  function automatic logic signed [ACC_W-1:0] sext(input logic signed [DATA_W-1:0] x);
    return ACC_W'(x);
  endfunction

  function automatic logic signed [DATA_W-1:0] round_avg4(input logic signed [ACC_W-1:0] sum);
    logic signed [ACC_W-1:0] r;
    r = (sum + RND_HALF) >>> 2;
    return r[DATA_W-1:0];
  endfunction

  // A level already high when reset releases must fall once before it can start a run.
  assign start_edge_s = bus.ch_avg_start & ~start_prev_r & start_arm_r;

  // Start edge detector, runs in every state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_prev_r <= 1'b0;
      start_arm_r  <= 1'b0;
    end else begin
      start_prev_r <= bus.ch_avg_start;
      start_arm_r  <= start_arm_r | ~bus.ch_avg_start;
    end
  end

  // Control state and registered read-side outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      rd_en_r  <= 1'b0;
      rd_sym_r <= 2'd0;
      rd_idx_r <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      rd_en_r  <= rd_en_s;
      rd_sym_r <= rd_sym_s;
      rd_idx_r <= rd_idx_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_s  = state_r;
    rd_en_s  = rd_en_r;
    rd_sym_s = rd_sym_r;
    rd_idx_s = rd_idx_r;
    busy_s   = busy_r;
    done_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_edge_s) begin
          state_s  = READ;
          rd_en_s  = 1'b1;
          rd_sym_s = 2'd0;
          rd_idx_s = '0;
          busy_s   = 1'b1;
        end else begin
          busy_s   = 1'b0;
        end
      end
      READ: begin
        if ((rd_sym_r == 2'd3) && (rd_idx_r == LAST_IDX)) begin
          state_s = DRAIN;
          rd_en_s = 1'b0;
        end else begin
          rd_sym_s = rd_sym_r + 2'd1;
          if (rd_sym_r == 2'd3) begin
            rd_idx_s = rd_idx_r + IDX_W'(1);
          end else begin
            rd_idx_s = rd_idx_r;
          end
        end
      end
      DRAIN: begin
        // busy stays up through the done cycle and drops from IDLE afterwards.
        if (wr_en_r && (wr_idx_r == LAST_IDX)) begin
          state_s = IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = IDLE;
        rd_en_s = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // Return path: accumulate the four symbols of an RE, round and write on the last.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_en_r   <= 1'b0;
      d_sym_r  <= 2'd0;
      d_idx_r  <= '0;
      acc_re_r <= '0;
      acc_im_r <= '0;
      wr_en_r  <= 1'b0;
      wr_idx_r <= '0;
      avg_re_r <= '0;
      avg_im_r <= '0;
    end else begin
      d_en_r  <= rd_en_r;
      d_sym_r <= rd_sym_r;
      d_idx_r <= rd_idx_r;
      wr_en_r <= 1'b0;
      if (d_en_r) begin
        case (d_sym_r)
          2'd0: begin
            acc_re_r <= sext(bus.est_re);
            acc_im_r <= sext(bus.est_im);
          end
          2'd1, 2'd2: begin
            acc_re_r <= acc_re_r + sext(bus.est_re);
            acc_im_r <= acc_im_r + sext(bus.est_im);
          end
          2'd3: begin
            avg_re_r <= round_avg4(acc_re_r + sext(bus.est_re));
            avg_im_r <= round_avg4(acc_im_r + sext(bus.est_im));
            wr_en_r  <= 1'b1;
            wr_idx_r <= d_idx_r;
          end
          default: begin
            acc_re_r <= acc_re_r;
            acc_im_r <= acc_im_r;
          end
        endcase
      end else begin
        acc_re_r <= acc_re_r;
        acc_im_r <= acc_im_r;
      end
    end
  end

  assign bus.avg_done   = done_r;
  assign bus.busy       = busy_r;
  assign bus.est_rd_en  = rd_en_r;
  assign bus.est_rd_sym = rd_sym_r;
  assign bus.est_rd_idx = rd_idx_r;
  assign bus.avg_wr_en  = wr_en_r;
  assign bus.avg_wr_idx = wr_idx_r;
  assign bus.avg_re     = avg_re_r;
  assign bus.avg_im     = avg_im_r;
endmodule

// File: tb/tb_ch_avg.sv
// Bench for ch_avg: an estimate-buffer model feeds randomized and directed
// sample sets; every write is checked against a floor((sum+2)/4) reference.
module tb_ch_avg;
  localparam int DATA_W   = 16;
  localparam int NUM_RE   = 60;
  localparam int IDX_W    = 6;
  localparam int LAST_RD  = 4 * NUM_RE;
  localparam int LAST_WR  = 4 * NUM_RE + 2;
  localparam int DONE_CYC = 4 * NUM_RE + 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic signed [DATA_W-1:0] mem_re [4][NUM_RE];
  logic signed [DATA_W-1:0] mem_im [4][NUM_RE];

  ch_avg_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

  ch_avg #(.DATA_W(DATA_W), .NUM_RE(NUM_RE), .IDX_W(IDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Per-symbol estimate buffer: data one cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.est_rd_en) begin
      bus.est_re <= mem_re[bus.est_rd_sym][bus.est_rd_idx];
      bus.est_im <= mem_im[bus.est_rd_sym][bus.est_rd_idx];
    end
  end

  function automatic int ref_avg(input int a, input int b, input int c, input int d);
    int t;
    t = a + b + c + d + 2;
    return (t >= 0) ? (t / 4) : -((-t + 3) / 4);
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input int mode);
    int re, im;
    for (int k = 0; k < NUM_RE; k++) begin
      for (int s = 0; s < 4; s++) begin
        case (mode)
          0: begin re = s + 1; im = 0; end
          1: begin
            if (k % 2 == 0) begin
              re = (s == 3) ? -2 : -1;
              im = (s < 2) ? 1 : 0;
            end else begin
              re = $signed(16'($urandom));
              im = (s < 2) ? -1 : 0;
            end
          end
          2: begin
            re = (k % 2 == 0) ? 32767 : -32768;
            im = (k % 2 == 0) ? -32768 : 32767;
          end
          default: begin
            re = $signed(16'($urandom));
            im = $signed(16'($urandom));
          end
        endcase
        mem_re[s][k] = DATA_W'(re);
        mem_im[s][k] = DATA_W'(im);
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk(tag, {bus.avg_done, bus.busy, bus.est_rd_en, bus.avg_wr_en, bus.est_rd_sym,
              bus.est_rd_idx, bus.avg_wr_idx, bus.avg_re, bus.avg_im}, 0);
  endtask

  // One run started from IDLE; start behaves like the controller unless
  // drop_at / pulse_at / rst_at perturb it.
  task automatic run(input string name, input int drop_at, input int pulse_at, input int rst_at);
    bit exp_rd, exp_busy, exp_wr, exp_done;
    int k;
    @(negedge clk);
    bus.ch_avg_start = 1'b1;
    for (int c = 1; c <= DONE_CYC + 6; c++) begin
      @(negedge clk);
      if (c == rst_at) begin
        rst = 1'b0;
        #1;
        chk({name, ":reset_outputs"}, 0, 0 | {bus.avg_done, bus.busy, bus.est_rd_en,
            bus.avg_wr_en, bus.est_rd_sym, bus.est_rd_idx, bus.avg_wr_idx, bus.avg_re, bus.avg_im});
        return;
      end
      exp_rd   = (c <= LAST_RD);
      exp_busy = (c <= DONE_CYC);
      exp_wr   = (c >= 6) && (c <= LAST_WR) && ((c - 6) % 4 == 0);
      exp_done = (c == DONE_CYC);
      chk({name, ":ctl"}, {bus.est_rd_en, bus.busy, bus.avg_wr_en, bus.avg_done},
          {exp_rd, exp_busy, exp_wr, exp_done});
      if (exp_rd) begin
        chk({name, ":rd_addr"}, {bus.est_rd_sym, bus.est_rd_idx},
            {2'((c - 1) % 4), IDX_W'((c - 1) / 4)});
      end
      if (exp_wr) begin
        k = (c - 6) / 4;
        chk({name, ":wr_idx"}, bus.avg_wr_idx, k);
        chk({name, ":avg_re"}, $signed(bus.avg_re),
            ref_avg(mem_re[0][k], mem_re[1][k], mem_re[2][k], mem_re[3][k]));
        chk({name, ":avg_im"}, $signed(bus.avg_im),
            ref_avg(mem_im[0][k], mem_im[1][k], mem_im[2][k], mem_im[3][k]));
      end
      if (bus.avg_done) bus.ch_avg_start = 1'b0;
      if (c == drop_at) bus.ch_avg_start = 1'b0;
      if (c == pulse_at) bus.ch_avg_start = 1'b0;
      if (pulse_at > 0 && c == pulse_at + 2) bus.ch_avg_start = 1'b1;
    end
    bus.ch_avg_start = 1'b0;
  endtask

  initial begin
    bus.ch_avg_start = 1'b0;
    bus.est_re = '0;
    bus.est_im = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("por_reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    fill(0);
    run("basic", 0, 0, 0);
    fill(1);
    run("round_pulse", 0, 50, 0);
    fill(2);
    run("extreme_drop", 20, 0, 0);
    fill(3);
    run("random", 0, 0, 0);
    fill(0);
    run("basic_again", 0, 0, 0);

    fill(3);
    run("rst_mid", 0, 0, 100);
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst_held");
    rst = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("post_rst_idle", {bus.est_rd_en, bus.busy, bus.avg_wr_en, bus.avg_done}, 0);
    end
    bus.ch_avg_start = 1'b0;
    @(negedge clk);
    run("after_rst", 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
